// File: rtl/tdm_mux_8_1.sv
// tdm_mux_8_1: round-robin TDM transmitter. Snapshots eight 1-bit channels
// into a shadow register and serializes them onto Y with the slot index on S,
// each slot held for SLOT_CYCLES clocks. Frames may be chained with no gap.
module tdm_mux_8_1 #(
  parameter int SLOT_CYCLES = 1  // legal range 1..256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  output logic       Y,
  output logic [2:0] S,
  output logic       valid,
  output logic       busy,
  output logic       frame_start,
  output logic       last
);

  typedef enum logic {IDLE, SEND} state_t;

  // Terminal count of the per-slot cycle counter; 256 maps to 255.
  localparam logic [7:0] TC = 8'(SLOT_CYCLES - 1);

  state_t     state;
  logic [7:0] shadow;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [7:0] d_in;
  logic [2:0] s_inc;
  logic       at_tc;
  logic       do_capture;

  // Next-value helpers and the capture condition (idle request, or chained
  // request in the final cycle of slot 7).
  always_comb begin
    d_in       = {D7, D6, D5, D4, D3, D2, D1, D0};
    cnt_inc    = cnt + 8'd1;
    s_inc      = S + 3'd1;
    at_tc      = (cnt == TC);
    do_capture = start && ((state == IDLE) || (state == SEND && last));
  end

  // Single-process FSM: all outputs are registered alongside the state.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values; blocking would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      // NOTE: the shadow register is small and cleared with everything else so
      // nothing observable depends on power-up contents.
      shadow      <= 8'd0;
      cnt         <= 8'd0;
      Y           <= 1'b0;
      S           <= 3'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      last        <= 1'b0;
    end else if (do_capture) begin
      // Y takes D0 straight from the inputs since shadow updates this edge.
      state       <= SEND;
      shadow      <= d_in;
      cnt         <= 8'd0;
      Y           <= d_in[0];
      S           <= 3'd0;
      valid       <= 1'b1;
      busy        <= 1'b1;
      frame_start <= 1'b1;
      last        <= 1'b0;
    end else if (state == SEND) begin
      frame_start <= 1'b0;
      if (last) begin
        // Frame complete with no chained request: drop back to idle values.
        state <= IDLE;
        cnt   <= 8'd0;
        Y     <= 1'b0;
        S     <= 3'd0;
        valid <= 1'b0;
        busy  <= 1'b0;
        last  <= 1'b0;
      end else if (at_tc) begin
        // Slot boundary: advance S and present the next captured channel.
        cnt  <= 8'd0;
        S    <= s_inc;
        Y    <= shadow[s_inc];
        last <= (s_inc == 3'd7) && (TC == 8'd0);
      end else begin
        cnt  <= cnt_inc;
        last <= (S == 3'd7) && (cnt_inc == TC);
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// tb_tdm_mux_8_1: scoreboard bench for tdm_mux_8_1. Stimulus pushes the
// expected per-cycle output into a queue; monitors pop and compare on every
// valid cycle. Two instances cover SLOT_CYCLES=1 and SLOT_CYCLES=3.
module tb_tdm_mux_8_1;

  typedef struct packed {
    logic       y;
    logic [2:0] s;
    logic       fs;
    logic       last;
    logic       contig;  // previous cycle must also have been valid
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1;
  logic       start3;
  logic [7:0] d;

  logic       y1, valid1, busy1, fs1, last1;
  logic [2:0] s1;
  logic       y3, valid3, busy3, fs3, last3;
  logic [2:0] s3;

  exp_t q1[$];
  exp_t q3[$];

  int   checks = 0;
  int   errors = 0;
  logic loop_phase = 1'b0;
  logic [7:0] rx = 8'd0;

  always #5 clk = ~clk;

  tdm_mux_8_1 #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .Y(y1), .S(s1), .valid(valid1), .busy(busy1),
    .frame_start(fs1), .last(last1)
  );

  tdm_mux_8_1 #(.SLOT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .Y(y3), .S(s3), .valid(valid3), .busy(busy3),
    .frame_start(fs3), .last(last3)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output for the first n_cycles cycles of a frame.
  task automatic push_frame(input int which, input int slot_cycles,
                            input logic [7:0] data, input logic chained,
                            input int n_cycles);
    exp_t e;
    for (int c = 0; c < n_cycles; c++) begin
      int n;
      n        = c / slot_cycles;
      e.y      = data[n];
      e.s      = 3'(n);
      e.fs     = (c == 0);
      e.last   = (c == 8 * slot_cycles - 1);
      e.contig = (c != 0) || chained;
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle1(input string name);
    check(name, {y1, s1, valid1, busy1, fs1, last1}, 32'd0);
  endtask

  task automatic check_idle3(input string name);
    check(name, {y3, s3, valid3, busy3, fs3, last3}, 32'd0);
  endtask

  // Monitor for the SLOT_CYCLES=1 instance, plus a demux_8_1 receiver model.
  always @(negedge clk) begin : mon1
    exp_t e;
    logic prev_valid;
    logic [7:0] demux_out;
    if (busy1 !== valid1) check("dut1_busy_eq_valid", busy1, valid1);
    if (valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_valid: got S=%0d Y=%0b expected no output at %0t",
                 s1, y1, $time);
      end else begin
        e = q1.pop_front();
        check("dut1_y_s_fs_last", {y1, s1, fs1, last1}, {e.y, e.s, e.fs, e.last});
        if (e.contig) check("dut1_contiguous_valid", prev_valid, 1'b1);
      end
      if (loop_phase) begin
        demux_out = 8'(y1) << s1;
        check("demux_out", demux_out, 8'h3C & (8'h01 << s1));
        if (fs1) rx = 8'd0;
        rx[s1] = y1;
      end
    end
    prev_valid = valid1;
  end

  // Monitor for the SLOT_CYCLES=3 instance.
  always @(negedge clk) begin : mon3
    exp_t e;
    logic prev_valid;
    if (busy3 !== valid3) check("dut3_busy_eq_valid", busy3, valid3);
    if (valid3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3_unexpected_valid: got S=%0d Y=%0b expected no output at %0t",
                 s3, y3, $time);
      end else begin
        e = q3.pop_front();
        check("dut3_y_s_fs_last", {y3, s3, fs3, last3}, {e.y, e.s, e.fs, e.last});
        if (e.contig) check("dut3_contiguous_valid", prev_valid, 1'b1);
      end
    end
    prev_valid = valid3;
  end

  initial begin
    // Reset held with start high and all-ones data: reset must win.
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1; d = 8'hFF;
    tick();
    check_idle1("reset_cycle1_dut1");
    check_idle3("reset_cycle1_dut3");
    tick();
    check_idle1("reset_cycle2_dut1");
    check_idle3("reset_cycle2_dut3");
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    tick();
    check_idle1("idle_after_reset");

    // Single frame: 8'b1011_0010 -> Y = 0,1,0,0,1,1,0,1.
    d = 8'b1011_0010; start1 = 1'b1;
    push_frame(1, 1, 8'b1011_0010, 1'b0, 8);
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    check_idle1("idle_after_single");

    // Snapshot: A5 captured, inputs flip to 5A right after capture.
    d = 8'hA5; start1 = 1'b1;
    push_frame(1, 1, 8'hA5, 1'b0, 8);
    tick();
    start1 = 1'b0; d = 8'h5A;
    repeat (9) tick();
    check_idle1("idle_after_snapshot");

    // SLOT_CYCLES=3: 24-cycle frame, each slot held 3 cycles.
    d = 8'h6C; start3 = 1'b1;
    push_frame(3, 3, 8'h6C, 1'b0, 24);
    tick();
    start3 = 1'b0; d = 8'h00;
    repeat (25) tick();
    check_idle3("idle_after_slot3");

    // Back-to-back: FF then 00, start held high across both frames.
    d = 8'hFF; start1 = 1'b1;
    push_frame(1, 1, 8'hFF, 1'b0, 8);
    push_frame(1, 1, 8'h00, 1'b1, 8);
    tick();
    repeat (7) tick();
    d = 8'h00;
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    check_idle1("idle_after_chain");

    // Mid-frame reset while S=100: aborted frame must not emit last.
    d = 8'hFF; start1 = 1'b1;
    push_frame(1, 1, 8'hFF, 1'b0, 5);
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    check("abort_at_slot4", s1, 3'd4);
    rst = 1'b1;
    tick();
    check_idle1("reset_abort");
    rst = 1'b0;

    // Loopback frame into the receiver model with D = 8'h3C.
    loop_phase = 1'b1;
    d = 8'h3C; start1 = 1'b1;
    push_frame(1, 1, 8'h3C, 1'b0, 8);
    tick();
    start1 = 1'b0;
    repeat (9) tick();
    loop_phase = 1'b0;
    check("loopback_rx", rx, 8'h3C);
    check_idle1("idle_after_loopback");

    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8_1.md
# tdm_mux_8_1

Round-robin time-division multiplexer that snapshots eight 1-bit channels and serializes them onto one line, driving the 3-bit select alongside the data. It is the transmit end of the channelized link whose receive end is `demux_8_1`: `Y` feeds the demultiplexer's `D` and `S` feeds its `S`, so `Y0..Y7` at the far end reconstruct `D0..D7`. A start/busy handshake frames each transfer, and back-to-back frames run with no idle gap.

## Interface
- `SLOT_CYCLES`, 1: clock cycles each channel is held on `Y`; legal range 1..256.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled on every rising edge while not busy, or in the `last` cycle.
- `D0`..`D7`  in  1 each  channel inputs; sampled only at frame capture.
- `Y`  out  1  serialized data; equals the captured channel indexed by `S`.
- `S`  out  3  current slot index, 000..111.
- `valid`  out  1  high while `Y`/`S` carry frame data.
- `busy`  out  1  frame in progress; equals `valid`.
- `frame_start`  out  1  one-cycle pulse on the first cycle of slot 0.
- `last`  out  1  high on the final cycle of slot 7.

## Operation
- There is one clock and reset is synchronous, active-high: `rst` sampled high on a rising edge forces state IDLE.
- Reset values: `Y`=0, `S`=000, `valid`=0, `busy`=0, `frame_start`=0, `last`=0, slot counter=0, shadow register=0.
- All outputs are registered, with no combinational path from input to output.
- FSM has two states, IDLE and SEND.
  - **IDLE:** outputs are at their reset values. When `start`=1 at an edge, capture `{D7..D0}` into an 8-bit shadow register, load `S`=000, clear the slot counter, and enter SEND.
  - **SEND:** `Y` = shadow[`S`], and `valid`=`busy`=1.
    - The slot counter (8 bits) counts 0..SLOT_CYCLES-1. At terminal count it wraps to 0 and `S` increments.
    - When `S`=111 and the counter is at terminal count, `last`=1.
    - At the edge ending the `last` cycle: if `start`=1, recapture `D0..D7`, set `S`=000, and stay in SEND with `frame_start`=1. Otherwise go to IDLE.
- `start` is ignored in SEND except during the `last` cycle. It is not queued.
- `D0..D7` changes during a frame do not affect the current frame, because the shadow register is loaded only at capture.
- `S` increments modulo 8. The wrap from 111 to 000 occurs only through recapture, never by free-running.
- When `SLOT_CYCLES`=1, every SEND cycle is a slot boundary, and `frame_start` and `last` are never high in the same cycle.
- Reset mid-frame aborts the frame. Outputs return to their reset values at that edge, and no `last` is emitted.
- When `rst` and `start` are both high at the same edge, reset wins.

## Timing
- Latency: with `start` sampled high at edge k, from edge k onward `S`=000, `Y`=D0 (as of edge k), `valid`=1, and `frame_start`=1 for that cycle.
- Frame length is exactly 8×SLOT_CYCLES cycles. Slot n occupies cycles n×SLOT_CYCLES .. (n+1)×SLOT_CYCLES−1 after capture.
- After the `last` cycle with `start`=0, `valid` falls at the next edge. A new `start` is accepted at the edge after that (one idle cycle minimum).
- Chained frames: when `start`=1 in the `last` cycle, there are 0 idle cycles and `valid` remains high continuously.
- `Y` and `S` change on the same edge and are always mutually consistent for the `demux_8_1` receiver.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `start`=1 and `D`=all ones -> `Y`=0, `S`=000, `valid`=`busy`=`frame_start`=`last`=0.
- **Single frame, SLOT_CYCLES=1:**
  - Stimulus: `{D7..D0}`=8'b1011_0010, pulse `start` for 1 cycle.
  - Required: over the next 8 cycles `S`=0..7 and `Y`=0,1,0,0,1,1,0,1. `frame_start` is high in cycle 1 only and `last` in cycle 8 only, then `valid`=0.
- **Snapshot:**
  - Stimulus: `{D7..D0}`=8'hA5 at capture, change to 8'h5A one cycle later.
  - Required: `Y` sequence is 1,0,1,0,0,1,0,1.
- **SLOT_CYCLES=3:** each `S` value is held for exactly 3 cycles, the frame lasts 24 cycles, and `last` is high only in cycle 24.
- **Back-to-back frames:**
  - Stimulus: hold `start`=1 over two frames, `D`=8'hFF then 8'h00 at the second capture.
  - Required: 16 consecutive `valid` cycles, `Y`=1 for 8 cycles then 0 for 8, and `frame_start` pulses in cycles 1 and 9.
- **Mid-frame reset and loopback:**
  - Stimulus: assert `rst` while `S`=100, then release it and start a new frame with `D`=8'h3C into a connected `demux_8_1`.
  - Required: the aborted frame emits no `last`. In the new frame, demux output `Y2..Y5` is 1 in slots 2..5, and every other demux output stays 0.
